adc_scan_controller: RTL

SPI master for the ADC128S022 8-channel 12-bit ADC on the line-follower board. Continuously scans the three line-sensor channels (5, 6, 7) and presents each latest 12-bit result on a held parallel register. Sits directly upstream of the sensor-threshold and PID stage, which consumes d_out_ch5/6/7. Raises a one-cycle strobe after every complete three-channel scan.

---
 rtl/adc_pkg.sv | 27 ++
 rtl/adc_scan_controller_sck_divider.sv | 32 +++
 rtl/adc_scan_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC128S022 scan controller: frame geometry,
// line-sensor channel addresses and the scan FSM state encoding.
package adc_pkg;

    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;

    localparam logic [2:0] CH5 = 3'd5;
    localparam logic [2:0] CH6 = 3'd6;
    localparam logic [2:0] CH7 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_e;

    function automatic logic [2:0] next_addr(input logic [2:0] a);
        return (a == CH7) ? CH5 : a + 3'd1;
    endfunction

    function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [2:0] a);
        return {2'b00, a, 11'b0};
    endfunction

endpackage

// File: rtl/adc_scan_controller_sck_divider.sv
// SCLK half-period divider: counts 0..SCLK_HALF-1 while running and flags the
// wrap cycle; held at zero whenever run_i is low so frames start phase-aligned.
module sck_divider #(
    parameter int SCLK_HALF = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tick_o
);

    localparam logic [4:0] LAST = 5'(SCLK_HALF - 1);

    logic [4:0] phase_q, phase_d;

    always_comb begin
        tick_o  = run_i && (phase_q == LAST);
        phase_d = phase_q + 5'd1;
        if (!run_i || tick_o) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/adc_scan_controller.sv
// Continuous SPI scan of ADC128S022 channels 5/6/7 with held parallel results
// and a one-cycle strobe after each complete three-channel scan.
module adc_scan_controller
    import adc_pkg::*;
#(
    parameter int SCLK_HALF = 16,
    parameter int GAP_HALF  = 1
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                en,
    output logic                adc_sck,
    output logic                adc_cs_n,
    output logic                din,
    input  logic                dout,
    output logic [ADC_BITS-1:0] d_out_ch5,
    output logic [ADC_BITS-1:0] d_out_ch6,
    output logic [ADC_BITS-1:0] d_out_ch7,
    output logic                scan_done
);

    state_e                state_q, state_d;
    logic [5:0]            half_q, half_d;
    logic [2:0]            addr_q, addr_d;
    logic [2:0]            prev_q, prev_d;
    logic                  primed_q, primed_d;
    logic                  upd_q, upd_d;
    logic [ADC_BITS-1:0]   sr_q, sr_d;
    logic                  sck_q, sck_d;
    logic                  cs_n_q, cs_n_d;
    logic                  din_q, din_d;
    logic [ADC_BITS-1:0]   ch5_q, ch5_d, ch6_q, ch6_d, ch7_q, ch7_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic [5:0]            h_next;
    logic [FRAME_BITS-1:0] ctrl;

    sck_divider #(.SCLK_HALF(SCLK_HALF)) u_div (
        .clk_i  (clk_50),
        .rst_i  (reset),
        .run_i  (state_q != ST_IDLE),
        .tick_o (tick)
    );

    assign h_next = half_q + 6'd1;
    assign ctrl   = ctrl_word(addr_q);

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        addr_d   = addr_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        upd_d    = 1'b0;
        sr_d     = sr_q;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        din_d    = din_q;
        ch5_d    = ch5_q;
        ch6_d    = ch6_q;
        ch7_d    = ch7_q;
        done_d   = 1'b0;

        // Result belongs to the address sent one frame earlier (ADC pipelining).
        if (upd_q && primed_q) begin
            case (prev_q)
                CH5:     ch5_d = sr_q;
                CH6:     ch6_d = sr_q;
                CH7: begin
                    ch7_d  = sr_q;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                cs_n_d   = 1'b1;
                sck_d    = 1'b1;
                din_d    = 1'b0;
                primed_d = 1'b0;
                half_d   = '0;
                if (en) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    half_d  = 6'd1;
                    sck_d   = 1'b0;
                    din_d   = ctrl[FRAME_BITS-1];
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (half_q == 6'd32) begin
                        state_d  = ST_GAP;
                        half_d   = '0;
                        cs_n_d   = 1'b1;
                        din_d    = 1'b0;
                        prev_d   = addr_q;
                        addr_d   = next_addr(addr_q);
                        primed_d = 1'b1;
                    end else begin
                        half_d = h_next;
                        if (h_next[0]) begin
                            sck_d = 1'b0;
                            din_d = ctrl[4'd15 - h_next[4:1]];
                        end else begin
                            sck_d = 1'b1;
                            // Bits 0..3 are the ADC's leading zeros.
                            if (h_next[5:1] >= 5'd5) begin
                                sr_d = {sr_q[ADC_BITS-2:0], dout};
                            end
                            upd_d = (h_next == 6'd32);
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (half_q == 6'(GAP_HALF - 1)) begin
                        half_d = '0;
                        if (en) begin
                            state_d = ST_SETUP;
                            cs_n_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        half_d = h_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            half_q   <= '0;
            addr_q   <= CH5;
            prev_q   <= CH5;
            primed_q <= 1'b0;
            upd_q    <= 1'b0;
            sr_q     <= '0;
            sck_q    <= 1'b1;
            cs_n_q   <= 1'b1;
            din_q    <= 1'b0;
            ch5_q    <= '0;
            ch6_q    <= '0;
            ch7_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            addr_q   <= addr_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            upd_q    <= upd_d;
            sr_q     <= sr_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            din_q    <= din_d;
            ch5_q    <= ch5_d;
            ch6_q    <= ch6_d;
            ch7_q    <= ch7_d;
            done_q   <= done_d;
        end
    end

    assign adc_sck   = sck_q;
    assign adc_cs_n  = cs_n_q;
    assign din       = din_q;
    assign d_out_ch5 = ch5_q;
    assign d_out_ch6 = ch6_q;
    assign d_out_ch7 = ch7_q;
    assign scan_done = done_q;

endmodule
